// File: rtl/lfsr_chk_pkg.sv
// Shared types and LFSR step/seed helpers for the LFSR stream checker.
// Also the source of the seed rewind used by the matching generator.
package lfsr_chk_pkg;

  localparam int CNT_W = 16;

  // Status word layout at the default counter width.
  typedef struct packed {
    logic             pass;
    logic [CNT_W-1:0] err_beats;
    logic [CNT_W-1:0] beats;
  } pkt_status_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } chk_state_e;

  function automatic logic [31:0] galois_step(
    input logic [31:0] s,
    input logic [31:0] poly
  );
    galois_step = (s >> 1) ^ (s[0] ? poly : 32'd0);
  endfunction

  function automatic logic [31:0] fib_step(
    input logic [31:0] s,
    input logic [31:0] poly,
    input int          deg
  );
    logic fb;
    fb = ^(s & poly);
    fib_step = (s >> 1) | (32'(fb) << (deg - 1));
  endfunction

  // Undo deg galois steps, so the first deg output bits of a packet
  // are the ones that lead the register back onto the seed.
  function automatic logic [31:0] prev_galois(
    input logic [31:0] seed,
    input logic [31:0] poly,
    input int          deg
  );
    logic [31:0] s;
    logic        b;
    s = seed;
    for (int i = 0; i < deg; i++) begin
      b = ((s >> (deg - 1)) & 32'd1) != 32'd0;
      if (b) s = s ^ poly;
      s = (s << 1) | 32'(b);
    end
    prev_galois = s;
  endfunction

endpackage

// File: rtl/lfsr_chk_status_reg.sv
// Packet status holding register with valid/ready output handshake.
// Ports: load/load_data in, status_tvalid/tdata/tready stream, space = can load.
module lfsr_chk_status_reg #(
  parameter int W = 33
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         status_tready,
  output logic         status_tvalid,
  output logic [W-1:0] status_tdata,
  output logic         space
);

  assign space = !status_tvalid || status_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      status_tvalid <= 1'b0;
      status_tdata  <= '0;
    end else if (load) begin
      status_tvalid <= 1'b1;
      status_tdata  <= load_data;
    end else if (status_tready) begin
      status_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi4s_lfsr_checker.sv
// Checks an AXI4-Stream of LFSR pattern beats; one status word per packet.
// Ports: target_* stream in, status_* stream out, clear, pkt/err totals.
// Macro LFSR_CHK_ERR_CAPTURE_EN adds first_err_* capture outputs.
module axi4s_lfsr_checker
  import lfsr_chk_pkg::*;
#(
  parameter int                     POLY_DEGREE    = 16,
  parameter logic [POLY_DEGREE-1:0] POLYNOMIAL     = 16'b1010000000010001,
  parameter logic [POLY_DEGREE-1:0] SEED           = POLY_DEGREE'(1),
  parameter int                     TDATA_WIDTH    = 8,
  parameter string                  IMPLEMENTATION = "galois",
  parameter int                     CNT_WIDTH      = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   target_tvalid,
  output logic                   target_tready,
  input  logic [TDATA_WIDTH-1:0] target_tdata,
  input  logic                   target_tlast,
  output logic                   status_tvalid,
  input  logic                   status_tready,
  output logic [2*CNT_WIDTH:0]   status_tdata,
  input  logic                   clear,
  output logic [31:0]            pkt_total,
  output logic [31:0]            err_pkt_total
`ifdef LFSR_CHK_ERR_CAPTURE_EN
  ,
  output logic                   first_err_valid,
  output logic [CNT_WIDTH-1:0]   first_err_beat,
  output logic [TDATA_WIDTH-1:0] first_err_exp,
  output logic [TDATA_WIDTH-1:0] first_err_got
`endif
);

  localparam logic [31:0] POLY32 = 32'(POLYNOMIAL);
  localparam logic [POLY_DEGREE-1:0] INTERNAL_SEED =
    (IMPLEMENTATION == "galois") ?
    POLY_DEGREE'(prev_galois(32'(SEED), POLY32, POLY_DEGREE)) : SEED;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  logic [POLY_DEGREE-1:0] lfsr_q;
  logic [POLY_DEGREE-1:0] lfsr_next;
  logic [TDATA_WIDTH-1:0] expected;
  logic [CNT_WIDTH-1:0]   beats_q;
  logic [CNT_WIDTH-1:0]   errs_q;
  logic [CNT_WIDTH-1:0]   beats_n;
  logic [CNT_WIDTH-1:0]   errs_n;
  chk_state_e             state_q;
  chk_state_e             state_d;
  logic                   accept;
  logic                   mismatch;
  logic                   last_acc;
  logic                   pass;

  if (IMPLEMENTATION == "galois") begin : g_gal
    always_comb begin : p_core
      logic [31:0] s;
      s = 32'(lfsr_q);
      expected = '0;
      for (int i = 0; i < TDATA_WIDTH; i++) begin
        expected[i] = s[0];
        s = galois_step(s, POLY32);
      end
      lfsr_next = POLY_DEGREE'(s);
    end
  end else if (IMPLEMENTATION == "fibonacci") begin : g_fib
    always_comb begin : p_core
      logic [31:0] s;
      s = 32'(lfsr_q);
      expected = '0;
      for (int i = 0; i < TDATA_WIDTH; i++) begin
        expected[i] = s[0];
        s = fib_step(s, POLY32, POLY_DEGREE);
      end
      lfsr_next = POLY_DEGREE'(s);
    end
  end else begin : g_bad
    $fatal(1, "IMPLEMENTATION must be galois or fibonacci");
  end

  assign accept   = target_tvalid && target_tready;
  assign last_acc = accept && target_tlast;
  assign mismatch = target_tdata != expected;
  assign beats_n  = (beats_q == CMAX) ? beats_q : beats_q + CNT_WIDTH'(1);
  assign errs_n   = (mismatch && errs_q != CMAX) ?
                    errs_q + CNT_WIDTH'(1) : errs_q;
  assign pass     = errs_n == '0;

  always_comb begin
    state_d = state_q;
    if (accept) state_d = target_tlast ? IDLE : ACTIVE;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      lfsr_q  <= INTERNAL_SEED;
      beats_q <= '0;
      errs_q  <= '0;
    end else begin
      state_q <= state_d;
      if (last_acc) begin
        lfsr_q  <= INTERNAL_SEED;
        beats_q <= '0;
        errs_q  <= '0;
      end else if (accept) begin
        lfsr_q  <= lfsr_next;
        beats_q <= beats_n;
        errs_q  <= errs_n;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_total     <= '0;
      err_pkt_total <= '0;
    end else if (clear) begin
      pkt_total     <= '0;
      err_pkt_total <= '0;
    end else if (last_acc) begin
      pkt_total     <= pkt_total + 32'd1;
      err_pkt_total <= err_pkt_total + 32'(!pass);
    end
  end

  lfsr_chk_status_reg #(
    .W (2*CNT_WIDTH+1)
  ) u_status (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .load          (last_acc),
    .load_data     ({pass, errs_n, beats_n}),
    .status_tready (status_tready),
    .status_tvalid (status_tvalid),
    .status_tdata  (status_tdata),
    .space         (target_tready)
  );

`ifdef LFSR_CHK_ERR_CAPTURE_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      first_err_valid <= 1'b0;
      first_err_beat  <= '0;
      first_err_exp   <= '0;
      first_err_got   <= '0;
    end else if (clear) begin
      first_err_valid <= 1'b0;
      first_err_beat  <= '0;
      first_err_exp   <= '0;
      first_err_got   <= '0;
    end else if (accept && mismatch && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_beat  <= beats_q;
      first_err_exp   <= expected;
      first_err_got   <= target_tdata;
    end
  end
`endif

endmodule

// File: tb/tb_axi4s_lfsr_checker.sv
// Bench for axi4s_lfsr_checker: stream-level model plus directed packets.
// Two instances (16- and 4-bit counters) share one stimulus stream.
module tb_axi4s_lfsr_checker;
  import lfsr_chk_pkg::*;

  localparam int POLY = 16'hA011;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b1;
  logic       target_tvalid = 1'b0;
  logic       target_tlast = 1'b0;
  logic [7:0] target_tdata = 8'h00;
  logic       status_tready = 1'b1;
  logic       clear = 1'b0;

  logic        tr_a, tr_b, sv_a, sv_b;
  logic [32:0] sd_a;
  logic [8:0]  sd_b;
  logic [31:0] pt_a, ept_a, pt_b, ept_b;
`ifdef LFSR_CHK_ERR_CAPTURE_EN
  logic        fv_a, fv_b;
  logic [15:0] fb_a;
  logic [3:0]  fb_b;
  logic [7:0]  fe_a, fg_a, fe_b, fg_b;
`endif

  int checks = 0;
  int errors = 0;
  int m_seed = 0;
  int hs_count = 0;
  logic [32:0] last_a = '0;
  logic [8:0]  last_b = '0;

  always #5 aclk = ~aclk;

  axi4s_lfsr_checker u_a (
    .aclk(aclk), .aresetn(aresetn),
    .target_tvalid(target_tvalid), .target_tready(tr_a),
    .target_tdata(target_tdata), .target_tlast(target_tlast),
    .status_tvalid(sv_a), .status_tready(status_tready),
    .status_tdata(sd_a), .clear(clear),
    .pkt_total(pt_a), .err_pkt_total(ept_a)
`ifdef LFSR_CHK_ERR_CAPTURE_EN
    , .first_err_valid(fv_a), .first_err_beat(fb_a),
    .first_err_exp(fe_a), .first_err_got(fg_a)
`endif
  );

  axi4s_lfsr_checker #(.CNT_WIDTH(4)) u_b (
    .aclk(aclk), .aresetn(aresetn),
    .target_tvalid(target_tvalid), .target_tready(tr_b),
    .target_tdata(target_tdata), .target_tlast(target_tlast),
    .status_tvalid(sv_b), .status_tready(status_tready),
    .status_tdata(sd_b), .clear(clear),
    .pkt_total(pt_b), .err_pkt_total(ept_b)
`ifdef LFSR_CHK_ERR_CAPTURE_EN
    , .first_err_valid(fv_b), .first_err_beat(fb_b),
    .first_err_exp(fe_b), .first_err_got(fg_b)
`endif
  );

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int lstep(input int s);
    return (s >> 1) ^ (((s & 1) != 0) ? POLY : 0);
  endfunction

  // Packet start state: the one whose 16 forward steps land on the seed.
  function automatic int find_seed();
    for (int c = 0; c < 65536; c++) begin
      int s;
      s = c;
      for (int k = 0; k < 16; k++) s = lstep(s);
      if (s == 1) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] beat_data(input int pos);
    int s;
    logic [7:0] d;
    s = m_seed;
    d = 8'h00;
    for (int k = 0; k < pos * 8 + 8; k++) begin
      d = {((s & 1) != 0), d[7:1]};
      s = lstep(s);
    end
    return d;
  endfunction

  function automatic int sat(input int x, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  // Stream-level model: a queue of owed status words and plain counters.
  logic [32:0] q_a[$];
  logic [8:0]  q_b[$];
  int m_pos = 0, m_b = 0, m_e = 0, m_pkt = 0, m_epkt = 0;
  bit m_fv = 0;
  int m_fbeat = 0, m_fexp = 0, m_fgot = 0;

  always @(posedge aclk or negedge aresetn) begin : p_model
    bit rdy, acc, mm, ps;
    if (!aresetn) begin
      q_a.delete();
      q_b.delete();
      m_pos = 0; m_b = 0; m_e = 0; m_pkt = 0; m_epkt = 0;
      m_fv = 0; m_fbeat = 0; m_fexp = 0; m_fgot = 0;
    end else begin
      rdy = (q_a.size() == 0) || status_tready;
      acc = target_tvalid && rdy;
      if (q_a.size() != 0 && status_tready) begin
        void'(q_a.pop_front());
        void'(q_b.pop_front());
      end
      if (acc) begin
        mm = target_tdata != beat_data(m_pos);
        if (mm && !m_fv && !clear) begin
          m_fv = 1; m_fbeat = m_pos;
          m_fexp = int'(beat_data(m_pos)); m_fgot = int'(target_tdata);
        end
        m_b++;
        m_e += int'(mm);
        m_pos++;
        if (target_tlast) begin
          ps = (m_e == 0);
          q_a.push_back({ps, 16'(sat(m_e, 16)), 16'(sat(m_b, 16))});
          q_b.push_back({ps, 4'(sat(m_e, 4)), 4'(sat(m_b, 4))});
          m_pkt++;
          m_epkt += int'(!ps);
          m_pos = 0; m_b = 0; m_e = 0;
        end
      end
      if (clear) begin
        m_pkt = 0; m_epkt = 0;
        m_fv = 0; m_fbeat = 0; m_fexp = 0; m_fgot = 0;
      end
    end
  end

  always @(negedge aclk) begin : p_cmp
    bit owe;
    owe = q_a.size() != 0;
    check("tready_a", tr_a, !owe || status_tready);
    check("tready_b", tr_b, !owe || status_tready);
    check("svalid_a", sv_a, owe);
    check("svalid_b", sv_b, owe);
    if (owe) begin
      check("sdata_a", sd_a, q_a[0]);
      check("sdata_b", sd_b, q_b[0]);
    end
    check("pkt_total_a", pt_a, 32'(m_pkt));
    check("err_total_a", ept_a, 32'(m_epkt));
    check("pkt_total_b", pt_b, 32'(m_pkt));
    check("err_total_b", ept_b, 32'(m_epkt));
`ifdef LFSR_CHK_ERR_CAPTURE_EN
    check("fe_valid", fv_a, m_fv);
    check("fe_beat", fb_a, 16'(m_fbeat));
    check("fe_exp", fe_a, 8'(m_fexp));
    check("fe_got", fg_a, 8'(m_fgot));
`endif
    if (sv_a && status_tready) begin
      hs_count++;
      last_a = sd_a;
      last_b = sd_b;
    end
  end

  task automatic beat(input logic [7:0] d, input logic l);
    bit ok;
    ok = 0;
    target_tvalid = 1'b1;
    target_tdata  = d;
    target_tlast  = l;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge aclk);
      ok = tr_a;
      @(posedge aclk);
      #1;
    end
    check("beat_accept", ok, 1);
    target_tvalid = 1'b0;
    target_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int n, input int bad1, input int bad2,
                          input logic [7:0] x, input bit all_bad);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d = beat_data(i);
      if (all_bad || i == bad1 || i == bad2) d = d ^ x;
      beat(d, i == n - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  pkt_status_t ok10, bad2_10, ok1, bad20;
  int h0;

  initial begin
    ok10    = '{pass: 1'b1, err_beats: 16'd0, beats: 16'd10};
    bad2_10 = '{pass: 1'b0, err_beats: 16'd2, beats: 16'd10};
    ok1     = '{pass: 1'b1, err_beats: 16'd0, beats: 16'd1};
    bad20   = '{pass: 1'b0, err_beats: 16'd20, beats: 16'd20};

    m_seed = find_seed();
    check("model_seed", 64'(m_seed), 64'h4023);
    check("model_beat0", beat_data(0), 8'h01);
    check("model_beat1", beat_data(1), 8'h00);
    check("model_beat2", beat_data(2), 8'h5F);

    #2 aresetn = 1'b0;
    @(posedge aclk);
    #1;
    check("rst_svalid", sv_a, 1'b0);
    check("rst_sdata", sd_a, 33'd0);
    check("rst_pkt", pt_a, 32'd0);
    check("rst_tready", tr_a, 1'b1);
    aresetn = 1'b1;
    idle(1);

    for (int p = 0; p < 3; p++) send_pkt(10, -1, -1, 8'h00, 0);
    idle(2);
    check("s1_status", last_a, ok10);
    check("s1_pkt", pt_a, 32'd3);
    check("s1_err", ept_a, 32'd0);
    check("s1_hs", 64'(hs_count), 64'd3);

    send_pkt(10, 2, 7, 8'h01, 0);
    idle(2);
    check("s2_status", last_a, bad2_10);
    check("s2_err", ept_a, 32'd1);
`ifdef LFSR_CHK_ERR_CAPTURE_EN
    check("s2_fe_beat", fb_a, 16'd2);
    check("s2_fe_got", fg_a, fe_a ^ 8'h01);
    check("s2_fe_exp", fe_a, beat_data(2));
`endif
    send_pkt(10, -1, -1, 8'h00, 0);
    idle(2);
    check("s2_clean", last_a, ok10);

    status_tready = 1'b0;
    h0 = hs_count;
    send_pkt(10, -1, -1, 8'h00, 0);
    idle(1);
    check("s3_stall", tr_a, 1'b0);
    fork
      send_pkt(10, -1, -1, 8'h00, 0);
      begin
        idle(6);
        status_tready = 1'b1;
      end
    join
    idle(2);
    check("s3_status", last_a, ok10);
    check("s3_hs", 64'(hs_count - h0), 64'd2);

    h0 = hs_count;
    for (int p = 0; p < 20; p++) beat(beat_data(0), 1'b1);
    idle(2);
    check("s4_hs", 64'(hs_count - h0), 64'd20);
    check("s4_status", last_a, ok1);

    send_pkt(20, -1, -1, 8'hFF, 1);
    idle(2);
    check("s5_sat_b", last_b, {1'b0, 4'd15, 4'd15});
    check("s5_wide_a", last_a, bad20);

    h0 = hs_count;
    for (int i = 0; i < 5; i++) beat(beat_data(i), 1'b0);
    aresetn = 1'b0;
    idle(2);
    aresetn = 1'b1;
    idle(1);
    check("s6_no_status", 64'(hs_count - h0), 64'd0);
    for (int i = 0; i < 3; i++) beat(beat_data(i), 1'b0);
    clear = 1'b1;
    beat(beat_data(3), 1'b1);
    clear = 1'b0;
    idle(2);
    check("s6_status", last_a, {1'b1, 16'd0, 16'd4});
    check("s6_hs", 64'(hs_count - h0), 64'd1);
    check("s6_pkt", pt_a, 32'd0);
    check("s6_err", ept_a, 32'd0);

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
